keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver: time-multiplexes column drive on a 4x4 matrix keypad and reads the row lines back.
- Debounces a single key press and emits a 4-bit hex key code with a one-cycle valid strobe.
- The code feeds the display digit registers upstream of the display mux.
- Keypad is passive: rows pulled up externally, columns driven active-low.

Parameters:
SCAN_DIV, 1000, clk cycles each column is driven before its rows are evaluated (>=4).
DEBOUNCE_CNT, 20000, consecutive stable clk cycles required to accept a press or a release (>=2).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
rows  input  4  keypad row lines, active-low, asynchronous to clk.
cols  output  4  keypad column drive, active-low one-hot; exactly one bit low at all times.
key_code  output  4  hex code of the last accepted key; holds value until the next accepted press.
key_valid  output  1  one-cycle pulse, asserted the same cycle key_code updates.
key_held  output  1  high while an accepted key remains pressed (through release debounce).

Behaviour:
- Clock and reset: clk drives all flops. reset is synchronous, active-high, and overrides all other logic.
- Reset values: cols=4'b1110 (col index 0), key_code=4'h0, key_valid=0, key_held=0, state=SCAN, column index=0, all counters=0.
- Synchronizer: rows pass through a 2-flop synchronizer (rs) before any use. The synchronizer flops reset to 4'b1111.
- Column drive: cols = ~(4'b0001 << col_idx). col_idx changes only when leaving SCAN with no press, or when returning to SCAN. Advance is col_idx+1 mod 4, so 3 wraps to 0.
- State SCAN:
  - slot_cnt counts 0..SCAN_DIV-1 and rows are evaluated only on the cycle slot_cnt==SCAN_DIV-1, which allows settling.
  - If rs==4'b1111: col_idx advances and slot_cnt=0.
  - Otherwise: capture r = lowest-index low bit of rs and c = col_idx, then go to DEBOUNCE with deb_cnt=0. col_idx does not advance.
- State DEBOUNCE:
  - Column stays fixed and only rs[r] is monitored.
  - If rs[r]==0: deb_cnt increments.
  - If rs[r]==1: go to SCAN with col_idx advanced and slot_cnt=0. This is bounce rejection; no output changes.
  - When deb_cnt reaches DEBOUNCE_CNT-1 with rs[r]==0: next cycle key_code=map(r,c), key_valid=1 for exactly one cycle, key_held=1, state goes to HELD with deb_cnt=0.
- State HELD:
  - Column stays fixed. Each cycle rs[r]==1 increments deb_cnt; any cycle with rs[r]==0 clears deb_cnt.
  - When deb_cnt reaches DEBOUNCE_CNT-1 with rs[r]==1: key_held=0, go to SCAN with col_idx advanced and slot_cnt=0.
  - Other keys pressed during HELD are ignored, with no key_valid. Each new key_valid requires a full release and a new scan.
- Key map, key_code=map(row,col):
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E,0,F,D
- Simultaneous keys in the same column: the lowest row index wins. Keys in different columns: the first column scanned wins.
- Latency: from a clean, stable press at the pins to key_valid is 2 sync cycles + remaining scan wait + DEBOUNCE_CNT + 1 cycles.
  - Worst case with the press just missed: about 4*SCAN_DIV + DEBOUNCE_CNT + 3.
- Reset mid-DEBOUNCE or mid-HELD: the next cycle shows reset values, key_held drops, and no key_valid is issued.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. No overflow is possible because counters clear at their terminal value.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8):
- Reset with rows=1111: cols cycles 1110->1101->1011->0111->1110 with a 4-cycle dwell each; key_valid stays 0 and key_held stays 0.
- Hold row1 low only while cols=1011 (key "6") for 40 cycles: exactly one key_valid pulse with key_code=4'h6. key_held rises with key_valid and cols freezes at 1011. After release for 8+ cycles, key_held=0 and cols advances to 0111.
- Row bounce: press "0" (row3/col1) and release after 3 low cycles, repeated 5 times, then hold for 20 cycles: exactly one key_valid, key_code=4'h0. No valid is issued during the bounce phase.
- Hold "5" (row1/col1), then additionally press "9" (row2/col2) before releasing "5": only key_valid for 4'h5. After both are released and "9" is re-pressed, key_valid for 4'h9.
- Press rows 0 and 2 together in col3 ("A" and "C"): key_code=4'hA. Release glitch in HELD (row high 5 cycles, low 1, high 8): key_held stays 1 until the final 8-high run.
- Assert reset for 1 cycle while in HELD on "D": the next cycle has cols=1110, key_held=0, key_code=0, and no key_valid. With the key still pressed, a fresh scan yields key_valid for 4'hD.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-multiplexed 4x4 keypad scanner with press/release debounce and hex key code output
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int DW = DEBOUNCE_CNT > 1 ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  state_t        r_state;
  logic [3:0]    r_rs1;
  logic [3:0]    r_rs2;
  logic [1:0]    r_col;
  logic [1:0]    r_row;
  logic [SW-1:0] r_slot;
  logic [DW-1:0] r_deb;
  logic [1:0]    w_low;
  logic          w_hit;
  logic          w_slot_end;
  logic          w_deb_end;
  assign w_low      = !r_rs2[0] ? 2'd0 : !r_rs2[1] ? 2'd1 : !r_rs2[2] ? 2'd2 : 2'd3;
  assign w_hit      = r_rs2[r_row];
  assign w_slot_end = r_slot == SW'(SCAN_DIV - 1);
  assign w_deb_end  = r_deb == DW'(DEBOUNCE_CNT - 1);
  assign cols       = ~(4'b0001 << r_col);
  // two-flop synchronizer for the asynchronous row lines, idle-high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs1 <= 4'hF;
      r_rs2 <= 4'hF;
    end else begin
      r_rs1 <= rows;
      r_rs2 <= r_rs1;
    end
  end
  // scan / debounce / held state machine; column stays parked on the captured key outside SCAN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= SCAN;
      r_col     <= 2'd0;
      r_row     <= 2'd0;
      r_slot    <= '0;
      r_deb     <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (r_state)
        SCAN: begin
          if (w_slot_end) begin
            r_slot <= '0;
            if (&r_rs2) r_col <= r_col + 2'd1;
            else begin
              r_row   <= w_low;
              r_deb   <= '0;
              r_state <= DEBOUNCE;
            end
          end else r_slot <= r_slot + 1'b1;
        end
        DEBOUNCE: begin
          if (w_hit) begin
            r_state <= SCAN;
            r_col   <= r_col + 2'd1;
            r_slot  <= '0;
          end else if (w_deb_end) begin
            key_code  <= KEYMAP[{r_row, r_col, 2'b00} +: 4];
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            r_deb     <= '0;
            r_state   <= HELD;
          end else r_deb <= r_deb + 1'b1;
        end
        HELD: begin
          if (!w_hit) r_deb <= '0;
          else if (w_deb_end) begin
            key_held <= 1'b0;
            r_deb    <= '0;
            r_slot   <= '0;
            r_col    <= r_col + 2'd1;
            r_state  <= SCAN;
          end else r_deb <= r_deb + 1'b1;
        end
        default: r_state <= SCAN;
      endcase
    end
  end
endmodule
